// File: rtl/pio_in_debounced.sv
// pio_in_debounced: Avalon-MM input PIO for board switches and buttons.
// Each of WIDTH inputs passes through a two-flop synchroniser and an optional
// debouncer. The debounced level is then edge-detected (rising, falling or
// either, chosen by EDGE_TYPE). Edges are latched per bit in edge_capture and
// cleared per bit by write-1-to-clear. Masked captures drive irq.
//
// Build option: define PIO_IN_DEBOUNCE_EN to include the per-bit debounce
// counters. Without it the synchronised input feeds edge detection directly
// and DEBOUNCE_CYCLES has no effect.
//
// Register map (readdata valid one cycle after address is presented):
//   0 data         (RO)   debounced level
//   1 raw          (RO)   synchronised level, diagnostic only
//   2 irq_mask     (RW)
//   3 edge_capture (R/W1C)
module pio_in_debounced #(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] db_s;
    logic [WIDTH-1:0] db_prev_q;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] edge_det_s;
    logic [WIDTH-1:0] clear_s;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q;
    logic [WIDTH-1:0] edge_capture_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             wr_s;
    logic             unused_wdata_s;

    assign wr_s = chipselect & ~write_n;

    // Only writedata[WIDTH-1:0] carries register content.
    assign unused_wdata_s = ^writedata;

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= {WIDTH{1'b0}};
            sync2_q <= {WIDTH{1'b0}};
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] db_q;
    logic [WIDTH-1:0] db_d;

    // Per-bit debounce: a new level must persist for DEBOUNCE_CYCLES cycles;
    // any return to the accepted level restarts the count.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = {CNT_W{1'b0}};
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = {CNT_W{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Debounce counter and accepted-level registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign db_s = db_q;
`else
    logic [CNT_W-1:0] unused_cnt_s;

    // Without debouncing the counter width is irrelevant.
    assign unused_cnt_s = CNT_W'(DEBOUNCE_CYCLES - 1);
    assign db_s         = sync2_q;
`endif

    // Previous accepted level, the reference for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_prev_q <= {WIDTH{1'b0}};
        end else begin
            db_prev_q <= db_s;
        end
    end

    assign rise_s = db_s & ~db_prev_q;
    assign fall_s = ~db_s & db_prev_q;

    // Select which transition sets a capture bit.
    always_comb begin
        edge_det_s = {WIDTH{1'b0}};
        case (EDGE_TYPE)
            32'sd0:  edge_det_s = rise_s;
            32'sd1:  edge_det_s = fall_s;
            default: edge_det_s = rise_s | fall_s;
        endcase
    end

    // Register writes: mask load and write-1-to-clear; a fresh edge beats a clear.
    always_comb begin
        irq_mask_d = irq_mask_q;
        clear_s    = {WIDTH{1'b0}};
        if (wr_s && (address == 2'd2)) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end else if (wr_s && (address == 2'd3)) begin
            clear_s = writedata[WIDTH-1:0];
        end else begin
            irq_mask_d = irq_mask_q;
        end
        edge_capture_d = (edge_capture_q & ~clear_s) | edge_det_s;
    end

    // Mask and capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q     <= {WIDTH{1'b0}};
            edge_capture_q <= {WIDTH{1'b0}};
        end else begin
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
        end
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        readdata_d = 32'd0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = db_s;
            2'd1:    readdata_d[WIDTH-1:0] = sync2_q;
            2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
            default: readdata_d = 32'd0;
        endcase
    end

    // Registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= 32'd0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_pio_in_debounced.sv
// Bench for pio_in_debounced: three instances (rising, falling, any edge)
// share one bus and one input port. A cycle-level behavioural model built
// from the register-level rules predicts readdata and irq of every instance
// after every clock edge; directed sections add fixed-value checks.
module tb_pio_in_debounced;

    localparam int W = 4;
    localparam int N = 4;
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int LAT = N + 3;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd_r, rd_f, rd_a;
    logic          irq_r, irq_f, irq_a;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // model state
    logic [W-1:0]  m_in_d1, m_s, m_db, m_dbp, m_mask;
    logic [W-1:0]  m_hist [N];
    logic [W-1:0]  m_cap [3];
    logic [31:0]   m_rd [3];

    pio_in_debounced #(.WIDTH(W), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(N)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_r),
        .in_port(in_port), .irq(irq_r));

    pio_in_debounced #(.WIDTH(W), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(N)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_f),
        .in_port(in_port), .irq(irq_f));

    pio_in_debounced #(.WIDTH(W), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(N)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in_port), .irq(irq_a));

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_in_d1 = '0; m_s = '0; m_db = '0; m_dbp = '0; m_mask = '0;
        for (int k = 0; k < N; k++) m_hist[k] = '0;
        for (int j = 0; j < 3; j++) begin
            m_cap[j] = '0;
            m_rd[j]  = 32'd0;
        end
    endtask

    // One clock edge of the reference: everything on the right-hand side is
    // the value just before the edge.
    task automatic model_edge();
        logic [W-1:0] db_view, new_db, rise, fall, clr;
        bit           all_diff;
`ifdef PIO_IN_DEBOUNCE_EN
        // keep the last N synchronised samples; a bit flips once all N of
        // them disagree with the accepted level
        for (int k = N - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_s;
        db_view = m_db;
        for (int i = 0; i < W; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (m_hist[k][i] == m_db[i]) all_diff = 1'b0;
            end
            new_db[i] = all_diff ? ~m_db[i] : m_db[i];
        end
`else
        db_view = m_s;
        new_db  = m_s;
`endif
        rise = db_view & ~m_dbp;
        fall = ~db_view & m_dbp;
        clr  = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
        for (int j = 0; j < 3; j++) begin
            case (address)
                2'd0:    m_rd[j] = 32'(db_view);
                2'd1:    m_rd[j] = 32'(m_s);
                2'd2:    m_rd[j] = 32'(m_mask);
                default: m_rd[j] = 32'(m_cap[j]);
            endcase
        end
        m_cap[0] = (m_cap[0] & ~clr) | rise;
        m_cap[1] = (m_cap[1] & ~clr) | fall;
        m_cap[2] = (m_cap[2] & ~clr) | rise | fall;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
        m_dbp   = db_view;
        m_db    = new_db;
        m_s     = m_in_d1;
        m_in_d1 = in_port;
    endtask

    task automatic compare_outputs();
        check_value("rd_rise",  rd_r, m_rd[0]);
        check_value("rd_fall",  rd_f, m_rd[1]);
        check_value("rd_any",   rd_a, m_rd[2]);
        check_value("irq_rise", 32'(irq_r), 32'(|(m_cap[0] & m_mask)));
        check_value("irq_fall", 32'(irq_f), 32'(|(m_cap[1] & m_mask)));
        check_value("irq_any",  32'(irq_a), 32'(|(m_cap[2] & m_mask)));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge();
        else         model_reset();
        #1;
        compare_outputs();
    endtask

    task automatic do_read(input logic [1:0] a);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        tick();
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic random_phase(input int phases);
        int hold;
        for (int p = 0; p < phases; p++) begin
            in_port = W'($urandom);
            hold    = $urandom_range(1, 8);
            for (int c = 0; c < hold; c++) begin
                address    = 2'($urandom);
                chipselect = ($urandom_range(0, 3) != 0);
                write_n    = ($urandom_range(0, 4) != 0);
                writedata  = $urandom;
                tick();
            end
        end
        write_n = 1'b1; writedata = 32'd0;
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; in_port = '0;
        model_reset();

        // reset state
        repeat (3) tick();
        check_value("rst_rd", rd_r, 32'd0);
        check_value("rst_irq", 32'(irq_r), 32'd0);
        reset_n = 1'b1;
        do_read(2'd0); check_value("rst_data", rd_r, 32'd0);
        do_read(2'd2); check_value("rst_mask", rd_r, 32'd0);
        do_read(2'd3); check_value("rst_cap", rd_r, 32'd0);
        check_value("rst_irq_rel", 32'(irq_r), 32'd0);

        // debounce latency and capture
        address = 2'd0;
        in_port = 4'b0010;
        repeat (LAT - 1) tick();
        check_value("db_early", rd_r, 32'd0);
        tick();
        check_value("db_accept", rd_r, 32'h2);
        repeat (3) tick();
        do_read(2'd3);
        check_value("cap_rise", rd_r, 32'h2);
        check_value("cap_fall", rd_f, 32'h0);
        check_value("cap_any",  rd_a, 32'h2);
        do_write(2'd2, 32'h2);
        check_value("irq_on",  32'(irq_r), 32'd1);
        check_value("irq_off", 32'(irq_f), 32'd0);
        do_write(2'd3, 32'h2);
        check_value("irq_clr", 32'(irq_r), 32'd0);
        do_read(2'd3);
        check_value("cap_clr", rd_r, 32'h0);

        // short pulse on bit 0
        in_port = 4'b0011;
        repeat (3) tick();
        in_port = 4'b0010;
        repeat (10) tick();
        do_read(2'd0);
        check_value("glitch_data", rd_r, 32'h2);
        do_read(2'd3);
`ifdef PIO_IN_DEBOUNCE_EN
        check_value("glitch_cap", rd_r, 32'h0);
`else
        check_value("pulse_cap", rd_r, 32'h1);
`endif

        // falling and any-edge behaviour on bit 3
        do_write(2'd3, 32'hF);
        in_port = 4'b1010;
        repeat (12) tick();
        do_read(2'd3);
        check_value("b3_up_rise", rd_r, 32'h8);
        check_value("b3_up_fall", rd_f, 32'h0);
        check_value("b3_up_any",  rd_a, 32'h8);
        do_write(2'd3, 32'hF);
        in_port = 4'b0010;
        repeat (12) tick();
        do_read(2'd3);
        check_value("b3_dn_rise", rd_r, 32'h0);
        check_value("b3_dn_fall", rd_f, 32'h8);
        check_value("b3_dn_any",  rd_a, 32'h8);

        // partial clear and clear colliding with a new edge
        do_write(2'd3, 32'hF);
        in_port = 4'b0111;
        repeat (12) tick();
        do_read(2'd3);
        check_value("cap_0x5", rd_r, 32'h5);
        do_write(2'd3, 32'h1);
        do_read(2'd3);
        check_value("partial_clr", rd_r, 32'h4);
        in_port = 4'b0110;
        repeat (12) tick();
        in_port = 4'b0111;
        address = 2'd3;
        repeat (LAT - 1) tick();
        do_write(2'd3, 32'h1);
        do_read(2'd3);
        check_value("edge_beats_clr", rd_r, 32'h5);

        // randomized traffic against the model
        random_phase(250);

        // asynchronous reset mid-run with inputs high at release
        in_port = 4'b1111;
        reset_n = 1'b0;
        #1;
        check_value("async_rst_rd", rd_a, 32'd0);
        check_value("async_rst_irq", 32'(irq_a), 32'd0);
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (LAT + 3) tick();
        do_read(2'd3);
        check_value("rel_high_rise", rd_r, 32'hF);

        random_phase(150);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
